down_counter_nb: RTL and testbench
==================================

Name: down_counter_nb

Overview:
- Parametrised, registered, loadable down-counter; successor to the fixed 4-bit combinational decrement-by-one path.
- Generalised in width and step size, with three underflow modes: wrap, saturate and auto-reload.
- Provides a zero flag, a per-cycle borrow pulse and a sticky underflow flag.
- Used as timer, loop-count and credit-count datapath element; single clock domain.

Parameters:
- WIDTH, 8, counter width in bits; legal range 2..32.
- STEP_W, 4, width of the step input; must satisfy STEP_W <= WIDTH.
- MODE, 0, underflow handling: 0 = wrap (mod 2^WIDTH), 1 = saturate at zero, 2 = auto-reload from the last loaded value.
- RESET_VAL, 0, count and reload-register value after reset; WIDTH bits.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value written to count and reload register on load.
- en  input  1  decrement enable.
- step  input  STEP_W  unsigned amount subtracted per enabled cycle.
- count  output  WIDTH  current counter value (registered).
- zero  output  1  high when count == 0 (combinational from count register).
- borrow  output  1  registered one-cycle pulse: the previous enabled decrement underflowed.
- uflow  output  1  sticky underflow flag.

Behaviour:
- Reset (asynchronous, rst high, any cycle, including mid-count):
  - count = RESET_VAL, reload_reg = RESET_VAL, borrow = 0, uflow = 0.
  - zero follows count, so zero = (RESET_VAL == 0).
  - Deassertion takes effect on the next rising clk edge; no extra latency.
- Priority per rising edge: rst > load > en. With neither load nor en, all registers hold and borrow = 0.
- Load (load = 1):
  - count <= load_val, reload_reg <= load_val, borrow <= 0, uflow <= 0.
  - en and step are ignored that cycle.
  - New count is visible the cycle after the edge (latency 1).
- Decrement (load = 0, en = 1):
  - diff = {1'b0, count} - {zero-extend(step) to WIDTH+1}; WIDTH+1-bit unsigned subtract.
  - No underflow (diff[WIDTH] = 0): count <= diff[WIDTH-1:0], borrow <= 0.
  - Underflow (diff[WIDTH] = 1, i.e. step > count), borrow <= 1 and uflow <= 1 in all modes; count depends on MODE:
    - MODE 0: count <= diff[WIDTH-1:0] (modular wrap).
    - MODE 1: count <= 0.
    - MODE 2: count <= reload_reg. Residual step is discarded; the reload is exact.
  - step == 0: count holds, borrow <= 0. This is not an underflow.
  - Reaching exactly 0 (step == count) is not an underflow: borrow stays 0 and zero asserts next cycle.
  - At count == 0 with step >= 1 the decrement underflows (MODE 1 stays at 0, borrow pulses).
- borrow:
  - Asserted exactly the cycle after each underflowing edge.
  - Back-to-back underflows keep it high continuously.
- uflow: set on any underflow, cleared only by load or rst.
- Fully synchronous datapath apart from rst. No combinational path from inputs to outputs; zero depends on count only.
- Illegal MODE values (3) behave as MODE 0. A simulation-time assertion fires on STEP_W > WIDTH.

Test Plan:
- Reset mid-operation: WIDTH=4, load 9, decrement step 1 for 3 cycles (count=6), pulse rst asynchronously between edges -> count=0, zero=1, borrow=0, uflow=0 immediately, without waiting for a clock edge.
- Wrap: MODE 0, WIDTH=4, load 3, en=1, step=5 -> next count=14 (0xE), borrow=1 for one cycle, uflow=1 sticky; next edge with step=1 -> count=13, borrow=0, uflow=1.
- Saturate: MODE 1, WIDTH=8, load 10, step=4 for 3 edges -> 6, 2, 0 with borrow 0, 0, 1; zero=1 after third; further edges hold 0 with borrow=1 each cycle.
- Exact zero: MODE 1, load 8, step=8 -> count=0, zero=1, borrow=0, uflow=0.
- Auto-reload: MODE 2, WIDTH=4, load 5, step=2 -> 3, 1, then 5 (reload) with borrow=1, then 3; step=0 holds count, borrow=0.
- Priority: load=1 and en=1 with load_val=7, step=3 on the same edge -> count=7, no decrement; uflow cleared from a prior 1.

Source files
------------

// File: rtl/down_counter_nb.sv
// rtl/down_counter_nb.sv - parametrised loadable down-counter with wrap, saturate or auto-reload underflow
// Registered count/reload/borrow/uflow; zero is decoded from the count register only.
module down_counter_nb #(
  parameter int              WIDTH     = 8,
  parameter int              STEP_W    = 4,
  parameter int              MODE      = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              en,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  count,
  output logic              zero,
  output logic              borrow,
  output logic              uflow
);

  // Unknown modes fall back to modular wrap.
  localparam int EFF_MODE = ((MODE == 1) || (MODE == 2)) ? MODE : 0;

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             borrow_q, borrow_d;
  logic             uflow_q, uflow_d;
  logic [WIDTH:0]   diff;

  // The extra MSB of the widened subtract is the underflow indicator.
  always_comb begin
    diff = {1'b0, count_q} - {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  end

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    borrow_d = 1'b0;
    uflow_d  = uflow_q;
    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      uflow_d  = 1'b0;
    end else if (en) begin
      if (diff[WIDTH]) begin
        borrow_d = 1'b1;
        uflow_d  = 1'b1;
        if (EFF_MODE == 1) begin
          count_d = '0;
        end else if (EFF_MODE == 2) begin
          count_d = reload_q;
        end else begin
          count_d = diff[WIDTH-1:0];
        end
      end else begin
        count_d = diff[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= RESET_VAL;
      reload_q <= RESET_VAL;
      borrow_q <= 1'b0;
      uflow_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      borrow_q <= borrow_d;
      uflow_q  <= uflow_d;
    end
  end

  assign count  = count_q;
  assign zero   = (count_q == '0);
  assign borrow = borrow_q;
  assign uflow  = uflow_q;

  a_step_fits: assert property (@(posedge clk) STEP_W <= WIDTH);

endmodule

// File: tb/tb_down_counter_nb.sv
// tb/tb_down_counter_nb.sv - self-checking bench for down_counter_nb in wrap, saturate and reload modes
// Three instances share one stimulus stream; an arithmetic model tracks each of them.
module tb_down_counter_nb;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic       en;
  logic [7:0] lv;
  logic [3:0] step;

  logic [3:0] c0, c2;
  logic [7:0] c1;
  logic       z0, z1, z2, b0, b1, b2, u0, u1, u2;

  always #5 clk = ~clk;

  down_counter_nb #(.WIDTH(4), .STEP_W(4), .MODE(0), .RESET_VAL(4'd0)) u_m0 (
    .clk(clk), .rst(rst), .load(load), .load_val(lv[3:0]), .en(en), .step(step),
    .count(c0), .zero(z0), .borrow(b0), .uflow(u0));

  down_counter_nb #(.WIDTH(8), .STEP_W(4), .MODE(1), .RESET_VAL(8'd3)) u_m1 (
    .clk(clk), .rst(rst), .load(load), .load_val(lv), .en(en), .step(step),
    .count(c1), .zero(z1), .borrow(b1), .uflow(u1));

  down_counter_nb #(.WIDTH(4), .STEP_W(4), .MODE(2), .RESET_VAL(4'd9)) u_m2 (
    .clk(clk), .rst(rst), .load(load), .load_val(lv[3:0]), .en(en), .step(step),
    .count(c2), .zero(z2), .borrow(b2), .uflow(u2));

  int tests = 0;
  int fails = 0;

  int wid[3] = '{4, 8, 4};
  int md[3]  = '{0, 1, 2};
  int rv[3]  = '{0, 3, 9};
  int m_cnt[3], m_rel[3], m_bor[3], m_uf[3];

  typedef struct {
    bit l;
    int v;
    bit e;
    int s;
    int ec;
    int eb;
    int eu;
  } vec_t;

  vec_t tbl[12];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = rv[i];
      m_rel[i] = rv[i];
      m_bor[i] = 0;
      m_uf[i]  = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int modv;
      modv = 1 << wid[i];
      if (load) begin
        m_cnt[i] = int'(lv) % modv;
        m_rel[i] = m_cnt[i];
        m_bor[i] = 0;
        m_uf[i]  = 0;
      end else if (en) begin
        if (int'(step) > m_cnt[i]) begin
          m_bor[i] = 1;
          m_uf[i]  = 1;
          if (md[i] == 1)      m_cnt[i] = 0;
          else if (md[i] == 2) m_cnt[i] = m_rel[i];
          else                 m_cnt[i] = m_cnt[i] - int'(step) + modv;
        end else begin
          m_cnt[i] = m_cnt[i] - int'(step);
          m_bor[i] = 0;
        end
      end else begin
        m_bor[i] = 0;
      end
    end
  endtask

  function automatic int dut_val(int i);
    case (i)
      0:       return (int'(c0) << 3) | (int'(z0) << 2) | (int'(b0) << 1) | int'(u0);
      1:       return (int'(c1) << 3) | (int'(z1) << 2) | (int'(b1) << 1) | int'(u1);
      default: return (int'(c2) << 3) | (int'(z2) << 2) | (int'(b2) << 1) | int'(u2);
    endcase
  endfunction

  task automatic check(string name, int i, int ec, int eb, int eu);
    int got, exp;
    exp = (ec << 3) | ((ec == 0) ? 4 : 0) | (eb << 1) | eu;
    got = dut_val(i);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s inst%0d: got count=%0d zero=%0d borrow=%0d uflow=%0d, want count=%0d zero=%0d borrow=%0d uflow=%0d",
               name, i, got >> 3, (got >> 2) & 1, (got >> 1) & 1, got & 1,
               ec, (ec == 0) ? 1 : 0, eb, eu);
    end
  endtask

  task automatic tick(bit l, int v, bit e, int s);
    load = l;
    lv   = v[7:0];
    en   = e;
    step = s[3:0];
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic async_reset_pulse(string name);
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) check(name, i, rv[i], 0, 0);
    #2 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; en = 1'b0; lv = 8'd0; step = 4'd0;
    model_reset();
    #3;
    for (int i = 0; i < 3; i++) check("reset_state", i, rv[i], 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Saturate-mode vectors, including priority and exact-zero corners.
    tbl[0]  = '{1, 10, 0, 0, 10, 0, 0};
    tbl[1]  = '{0, 0,  1, 4, 6,  0, 0};
    tbl[2]  = '{0, 0,  1, 4, 2,  0, 0};
    tbl[3]  = '{0, 0,  1, 4, 0,  1, 1};
    tbl[4]  = '{0, 0,  1, 4, 0,  1, 1};
    tbl[5]  = '{0, 0,  1, 0, 0,  0, 1};
    tbl[6]  = '{1, 7,  1, 3, 7,  0, 0};
    tbl[7]  = '{1, 8,  0, 0, 8,  0, 0};
    tbl[8]  = '{0, 0,  1, 8, 0,  0, 0};
    tbl[9]  = '{0, 0,  0, 0, 0,  0, 0};
    tbl[10] = '{0, 0,  1, 1, 0,  1, 1};
    tbl[11] = '{0, 0,  0, 5, 0,  0, 1};
    for (int k = 0; k < 12; k++) begin
      tick(tbl[k].l, tbl[k].v, tbl[k].e, tbl[k].s);
      check($sformatf("sat_vec%0d", k), 1, tbl[k].ec, tbl[k].eb, tbl[k].eu);
    end

    tick(1, 3, 0, 0);
    tick(0, 0, 1, 5);
    check("wrap_under", 0, 14, 1, 1);
    tick(0, 0, 1, 1);
    check("wrap_after", 0, 13, 0, 1);

    tick(1, 5, 0, 0);
    tick(0, 0, 1, 2);
    check("reload_3", 2, 3, 0, 0);
    tick(0, 0, 1, 2);
    check("reload_1", 2, 1, 0, 0);
    tick(0, 0, 1, 2);
    check("reload_hit", 2, 5, 1, 1);
    tick(0, 0, 1, 2);
    check("reload_next", 2, 3, 0, 1);
    tick(0, 0, 1, 0);
    check("reload_step0", 2, 3, 0, 1);

    tick(1, 9, 0, 0);
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 1);
    check("midop_count", 0, 6, 0, 0);
    async_reset_pulse("async_reset");

    // Reload register must hold RESET_VAL straight out of reset.
    tick(0, 0, 1, 10);
    check("reload_after_rst", 2, 9, 1, 1);
    check("wrap_after_rst", 0, 6, 1, 1);
    check("sat_after_rst", 1, 0, 1, 1);

    for (int n = 0; n < 400; n++) begin
      bit l, e;
      l = ($urandom_range(0, 9) == 0);
      e = ($urandom_range(0, 9) < 7);
      tick(l, int'($urandom_range(0, 255)), e, int'($urandom_range(0, 15)));
      for (int i = 0; i < 3; i++) check("random", i, m_cnt[i], m_bor[i], m_uf[i]);
      if ($urandom_range(0, 49) == 0) async_reset_pulse("random_reset");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
